// File: rtl/uart_word_tx_if.sv
// Word-side handshake between a producer and uart_word_tx.
// The producer drives word/wrt_en; the transmitter returns ready/busy/Tx_Done.
interface uart_word_tx_if #(
  parameter int unsigned NBYTES = 4
);
  logic [8*NBYTES-1:0] word;
  logic                wrt_en;
  logic                ready;
  logic                busy;
  logic                Tx_Done;

  modport master (output word, wrt_en, input ready, busy, Tx_Done);
  modport slave  (input word, wrt_en, output ready, busy, Tx_Done);
endinterface

// File: rtl/uart_word_tx.sv
// Serialises an NBYTES-wide word as back-to-back 8N1 UART frames, with an optional header
// byte and selectable byte order; a one-word holding register lets words stream gap-free.
module uart_word_tx #(
  parameter int unsigned CLK_FREQ  = 50_000_000,
  parameter int unsigned BAUD      = 115200,
  parameter int unsigned NBYTES    = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          HEADER_EN = 1'b0,
  parameter logic [7:0]  HEADER    = 8'hA5
) (
  input  logic              Clk,
  input  logic              Rst_n,
  uart_word_tx_if.slave     bus,
  output logic              Rs232_Tx
);
  localparam int unsigned BAUD_DIV = CLK_FREQ / BAUD;
  localparam int unsigned CNT_W    = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int unsigned BIT_W    = $clog2(10);
  localparam int unsigned NB       = NBYTES + (HEADER_EN ? 1 : 0);
  localparam int unsigned BYTE_W   = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned WORD_W   = 8 * NBYTES;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    baud_q, baud_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [BYTE_W-1:0]   byte_q, byte_d;
  logic [7:0]          shreg_q, shreg_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [WORD_W-1:0]   hold_q, hold_d;
  logic                full_q, full_d;
  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                tx_q, tx_d;
  logic                tick;
  logic                load;

  // Byte transmitted in a given slot of the word: header first, then data in configured order.
  function automatic logic [7:0] pick_byte(input logic [WORD_W-1:0] w, input int unsigned slot);
    logic [7:0]  r;
    int unsigned k;
    int unsigned pos;
    r   = HEADER;
    k   = 0;
    pos = 0;
    if (!(HEADER_EN && slot == 0)) begin
      k   = slot - 32'(HEADER_EN);
      pos = MSB_FIRST ? (NBYTES - 1 - k) : k;
      for (int unsigned p = 0; p < NBYTES; p++) begin
        if (p == pos) r = w[8*p +: 8];
      end
    end
    return r;
  endfunction

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      shreg_q <= '0;
      word_q  <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      shreg_q <= shreg_d;
      word_q  <= word_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;
    word_d  = word_q;
    hold_d  = hold_q;
    full_d  = full_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    tx_d    = tx_q;
    load    = 1'b0;
    tick    = (baud_q == CNT_W'(BAUD_DIV - 1));

    if (state_q != IDLE) baud_d = tick ? '0 : baud_q + CNT_W'(1);

    case (state_q)
      IDLE: begin
        if (full_q) load = 1'b1;
      end
      START: begin
        if (tick) begin
          state_d = DATA;
          tx_d    = shreg_q[0];
          shreg_d = {1'b0, shreg_q[7:1]};
          bit_d   = BIT_W'(1);
        end
      end
      DATA: begin
        if (tick) begin
          if (bit_q == BIT_W'(8)) begin
            state_d = STOP;
            tx_d    = 1'b1;
            bit_d   = BIT_W'(9);
          end else begin
            tx_d    = shreg_q[0];
            shreg_d = {1'b0, shreg_q[7:1]};
            bit_d   = bit_q + BIT_W'(1);
          end
        end
      end
      STOP: begin
        if (tick) begin
          bit_d = '0;
          if (byte_q != BYTE_W'(NB - 1)) begin
            byte_d  = byte_q + BYTE_W'(1);
            shreg_d = pick_byte(word_q, 32'(byte_q) + 32'd1);
            tx_d    = 1'b0;
            state_d = START;
          end else begin
            // End of word: pulse done and chain straight into a pending word if there is one
            done_d = 1'b1;
            byte_d = '0;
            if (full_q) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      word_d  = hold_q;
      shreg_d = pick_byte(hold_q, 32'd0);
      full_d  = 1'b0;
      state_d = START;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
      bit_d   = '0;
      byte_d  = '0;
      baud_d  = '0;
    end

    if (bus.wrt_en && ready_q) begin
      hold_d = bus.word;
      full_d = 1'b1;
    end

    ready_d = !full_d;
  end

  assign bus.ready   = ready_q;
  assign bus.busy    = busy_q;
  assign bus.Tx_Done = done_q;
  assign Rs232_Tx    = tx_q;
endmodule
